// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: host controller states, defaults,
// the standard initial hash value and the "abc" reference digest.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_DATA,
    S_REPORT
  } host_state_t;

  localparam int DIGEST_WORDS_DEF   = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  localparam logic [255:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] SHA256_ABC = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  function automatic logic [31:0] digest_word(
    input logic [255:0] d,
    input int           k
  );
    return d[255-32*k -: 32];
  endfunction

endpackage

// File: rtl/sha256_host_ctrl_if.sv
// Engine start/done handshake plus the shared read-only memory port.
// master = host controller, slave = engine / memory side.
interface sha256_host_ctrl_if;

  logic        sha_start;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic        sha_done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;

  modport master (
    output sha_start,
    output sha_message_addr,
    output sha_output_addr,
    input  sha_done,
    output mem_clk,
    output mem_we,
    output mem_addr,
    input  mem_read_data
  );

  modport slave (
    input  sha_start,
    input  sha_message_addr,
    input  sha_output_addr,
    output sha_done,
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    output mem_read_data
  );

endinterface

// File: rtl/sha256_host_ctrl.sv
// Launches one SHA-256 run, waits for completion, reads the digest
// back from shared memory and compares it against a reference.
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int DIGEST_WORDS   = DIGEST_WORDS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_go,
  input  logic [15:0]               i_msg_addr,
  input  logic [15:0]               i_out_addr,
  input  logic [32*DIGEST_WORDS-1:0] i_expected,
  sha256_host_ctrl_if.master        eng,
  output logic [32*DIGEST_WORDS-1:0] o_digest,
  output logic                      o_busy,
  output logic                      o_result_valid,
  output logic                      o_match,
  output logic                      o_timeout
);

  localparam int DW = 32 * DIGEST_WORDS;
  localparam int IW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(DIGEST_WORDS - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  host_state_t   r_state;
  host_state_t   w_next;
  logic [15:0]   r_msg;
  logic [15:0]   r_out;
  logic [15:0]   r_mem_addr;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_cnt;
  logic [DW-1:0] r_digest;
  logic          r_match;
  logic          r_timeout;
  logic          w_tmo_hit;
  logic          w_wait_ok;
  logic          w_last;
  logic [DW-1:0] w_dig_new;

  assign w_tmo_hit = (r_cnt == TLIM);
  assign w_last    = (r_idx == LAST);
  // WAIT_BUSY waits for done to fall, WAIT_DONE for it to rise
  assign w_wait_ok = (r_state == S_WAIT_BUSY) ? !eng.sha_done
                                              : eng.sha_done;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_REPORT: if (i_go) w_next = S_LAUNCH;
      S_LAUNCH:         w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_wait_ok)      w_next = S_WAIT_DONE;
        else if (w_tmo_hit) w_next = S_REPORT;
      end
      S_WAIT_DONE: begin
        if (w_wait_ok)      w_next = S_RD_ADDR;
        else if (w_tmo_hit) w_next = S_REPORT;
      end
      S_RD_ADDR:        w_next = S_RD_DATA;
      S_RD_DATA:        w_next = w_last ? S_REPORT : S_RD_ADDR;
      default:          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_dig_new = r_digest;
    for (int k = 0; k < DIGEST_WORDS; k++) begin
      if (r_idx == IW'(k)) w_dig_new[DW-1-32*k -: 32] = eng.mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_msg      <= '0;
      r_out      <= '0;
      r_mem_addr <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_digest   <= '0;
      r_match    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_REPORT: begin
          if (i_go) begin
            r_msg     <= i_msg_addr;
            r_out     <= i_out_addr;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_digest  <= '0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (!w_tmo_hit) r_cnt <= r_cnt + TW'(1);
          if (w_wait_ok) begin
            if (r_state == S_WAIT_DONE)
              r_mem_addr <= r_out + 16'(r_idx);
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
          end
        end
        S_RD_DATA: begin
          r_digest <= w_dig_new;
          // compare against the word being captured this cycle
          if (w_last) begin
            r_match <= (w_dig_new == i_expected);
          end else begin
            r_idx      <= r_idx + IW'(1);
            r_mem_addr <= r_mem_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng.sha_start        = (r_state == S_LAUNCH);
  assign eng.sha_message_addr = r_msg;
  assign eng.sha_output_addr  = r_out;
  assign eng.mem_clk          = clk;
  assign eng.mem_we           = 1'b0;
  assign eng.mem_addr         = r_mem_addr;

  assign o_digest       = r_digest;
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_REPORT);
  assign o_result_valid = (r_state == S_REPORT);
  assign o_match        = r_match;
  assign o_timeout      = r_timeout;

endmodule

// File: doc/sha256_host_ctrl.md
Name: sha256_host_ctrl

Overview:
- Initiator and result reader for the SHA-256 engine.
- Launches one hash run through the engine's start/done handshake, waits for the engine to return to idle, then reads the 8-word digest back from shared word-addressed memory at out_addr.
- Presents the digest as a 256-bit word and compares it against an expected value.
- Sits between the test/host sequencer and the engine and its memory port; it is the consumer of what the engine writes.

Parameters:
- DIGEST_WORDS, 8, number of 32-bit digest words read back.
- TIMEOUT_CYCLES, 4096, maximum cycles from launch to the engine's done before the run is aborted.

Ports:
- clk  in  1  single clock for the block, the engine and memory.
- reset_n  in  1  synchronous, active-low reset.
- go  in  1  one-cycle request to start a run; sampled only in IDLE or REPORT.
- msg_addr  in  16  word address of the message; forwarded to the engine.
- out_addr  in  16  word address of the digest; forwarded to the engine and used for readback.
- expected  in  256  reference digest; word 0 is bits [255:224].
- sha_start  out  1  start pulse to the engine.
- sha_message_addr  out  16  registered copy of msg_addr.
- sha_output_addr  out  16  registered copy of out_addr.
- sha_done  in  1  engine done; high whenever the engine is idle.
- mem_clk  out  1  equals clk.
- mem_we  out  1  constant 0 (read-only port).
- mem_addr  out  16  readback address.
- mem_read_data  in  32  synchronous RAM data, valid one cycle after mem_addr.
- digest  out  256  captured digest; word k occupies bits [255-32k -: 32].
- busy  out  1  high in every state except IDLE and REPORT.
- result_valid  out  1  high in REPORT.
- match  out  1  digest == expected; meaningful only when result_valid=1.
- timeout  out  1  the run was aborted by timeout; meaningful only when result_valid=1.

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - State goes to IDLE.
  - sha_start=0, mem_addr=0, digest=0, result_valid=0, match=0, timeout=0.
  - sha_message_addr and sha_output_addr go to 0.
  - Reset in any state, including mid-readback, aborts the run with no partial result.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_DATA, REPORT.
- IDLE or REPORT with go=1:
  - Latch msg_addr and out_addr into the sha_* outputs.
  - Clear digest, match, timeout and result_valid.
  - Clear the timeout counter and the word index idx.
  - Go to LAUNCH.
  - go in any other state is ignored.
- LAUNCH: sha_start=1 for exactly this one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for sha_done=0, i.e. the engine has left its idle state.
  - The engine's done is high before start, so a high done here must not be taken as completion.
  - On sha_done=0, go to WAIT_DONE.
- WAIT_DONE: on sha_done=1, set mem_addr=out_addr+idx and go to RD_ADDR.
- Timeout:
  - The counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 with the wait not yet satisfied: go to REPORT with timeout=1, match=0, digest left at 0.
- RD_ADDR: address is held on mem_addr; go to RD_DATA.
- RD_DATA:
  - Capture mem_read_data into digest word idx.
  - If idx==DIGEST_WORDS-1, go to REPORT.
  - Otherwise idx+1 and mem_addr+1, back to RD_ADDR.
  - Readback therefore takes 2*DIGEST_WORDS cycles (16 by default).
- Address arithmetic: 16-bit, wraps modulo 2^16 (out_addr=16'hFFFC reads FFFC..FFFF, then 0000..0003).
- REPORT:
  - result_valid=1.
  - match is registered on entry as digest==expected and held steady.
  - Stays in REPORT until go=1 or reset.
- Latency with default parameters:
  - go to sha_start: 1 cycle.
  - Final sha_done rise to result_valid: 1+16 cycles.
- sha_done toggling during the readback states is ignored.

Decomposition:
- Package sha256_pkg:
  - state enum host_state_t.
  - DIGEST_WORDS default.
  - Standard SHA-256 initial hash constants and the test vector for "abc", shared with the engine bench.
- No sub-module; the timeout counter and the readback sequencer are small enough to stay inline.

Test Plan:
- Bench engine stub drops done 1 cycle after start and raises it 200 cycles later; memory at out_addr=16'h0100 preloaded with ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; expected set to the same value; go -> sha_start pulses once, mem_addr steps 0100..0107, digest equals those words, match=1, timeout=0, result_valid 17 cycles after done rises.
- Same run with expected word 7 changed to f20015ae -> result_valid=1, match=0, digest unchanged.
- Stub never drops done -> WAIT_BUSY times out after 4096 cycles: result_valid=1, timeout=1, match=0, digest=0.
- out_addr=16'hFFFC -> readback addresses FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- go pulsed during WAIT_DONE and again during readback -> ignored, exactly one sha_start; go in REPORT starts a second run with result_valid cleared the next cycle.
- reset_n=0 for 1 cycle at readback word 3 -> next cycle in IDLE with all outputs 0; no sha_start until a new go.
